// File: rtl/keypad_scan_if.sv
// ---------------------------------------------------------------------------
// keypad_scan_if: keypad matrix and key-code signals of keypad_scan.
//
// Signals (names are seen from the scanner side):
//   row_i          keypad rows, active-low, asynchronous to clk
//   col_o          column drive, one-cold (driven column reads 0)
//   keyboard_val_o last accepted key code {row_idx, col_idx}
//   key_valid_o    level: high while the accepted key is held
//   key_pulse_o    strobe: one cycle per accepted press (and per repeat)
//
// Transfer semantics: there is no backpressure. The consumer samples
// keyboard_val_o on any cycle where key_pulse_o is high. key_valid_o is a
// qualifying level only, and keyboard_val_o stays stable between pulses.
//
// Modports: master = the scanner, slave = the keypad/consumer side.
// ---------------------------------------------------------------------------
interface keypad_scan_if;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] keyboard_val_o;
  logic       key_valid_o;
  logic       key_pulse_o;

  modport master (
    input  row_i,
    output col_o,
    output keyboard_val_o,
    output key_valid_o,
    output key_pulse_o
  );

  modport slave (
    output row_i,
    input  col_o,
    input  keyboard_val_o,
    input  key_valid_o,
    input  key_pulse_o
  );
endinterface

// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan: 4x4 active-low matrix keypad scanner with debounce.
//
// Ports:
//   clk_i      system clock
//   reset_n_i  asynchronous active-low reset
//   kp         keypad_scan_if.master (rows in, columns/key code out)
//   state_o    debug view of the FSM state (0 SCAN, 1 DEBOUNCE,
//              2 HELD, 3 RELEASE)
//
// Parameters:
//   SCAN_DIV      cycles each column is driven before sampling (>= 4)
//   DEBOUNCE_CNT  stable cycles to accept a press or release (>= 2)
//   REPEAT_CNT    auto-repeat period, only with KEYPAD_REPEAT_EN
//
// Build option: define KEYPAD_REPEAT_EN to enable auto-repeat pulses while
// a key stays held. Without it exactly one pulse is issued per press.
// ---------------------------------------------------------------------------
module keypad_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 500000,
  parameter int unsigned REPEAT_CNT   = 25000000
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  keypad_scan_if.master        kp,
  output logic [1:0]           state_o
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned SW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, row_s_q;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [3:0]    row_cap_q, row_cap_d;
  logic [3:0]    val_q, val_d;
  logic          valid_q, valid_d;
  logic          pulse_q, pulse_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CNT);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CNT - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  // Lowest pressed row wins when several keys share the frozen column.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_SCAN;
      sync1_q   <= 4'hF;
      row_s_q   <= 4'hF;
      col_idx_q <= 2'd0;
      dwell_q   <= '0;
      stable_q  <= '0;
      row_cap_q <= 4'hF;
      val_q     <= 4'h0;
      valid_q   <= 1'b0;
      pulse_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= kp.row_i;
      row_s_q   <= sync1_q;
      col_idx_q <= col_idx_d;
      dwell_q   <= dwell_d;
      stable_q  <= stable_d;
      row_cap_q <= row_cap_d;
      val_q     <= val_d;
      valid_q   <= valid_d;
      pulse_q   <= pulse_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    dwell_d   = dwell_q;
    stable_d  = stable_q;
    row_cap_d = row_cap_q;
    val_d     = val_q;
    valid_d   = valid_q;
    pulse_d   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
`endif
    case (state_q)
      S_SCAN: begin
        // Rows are only trusted in the last dwell cycle, once the
        // synchronizer holds values taken under the current column.
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row_s_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_cap_d = row_s_q;
            stable_d  = '0;
            state_d   = S_DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (row_s_q != row_cap_q) begin
          dwell_d = '0;
          state_d = S_SCAN;
        end else if (stable_q == STABLE_LAST) begin
          val_d   = {low_row(row_cap_q), col_idx_q};
          valid_d = 1'b1;
          pulse_d = 1'b1;
          state_d = S_HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          stable_d = stable_q + SW'(1);
        end
      end
      S_HELD: begin
`ifdef KEYPAD_REPEAT_EN
        // Not cleared in RELEASE, so a bounce back to HELD keeps the phase.
        if (rep_q == REPEAT_LAST) begin
          rep_d   = '0;
          pulse_d = 1'b1;
        end else begin
          rep_d = rep_q + RW'(1);
        end
`endif
        if (row_s_q == 4'hF) begin
          stable_d = '0;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (row_s_q != 4'hF) begin
          state_d = S_HELD;
        end else if (stable_q == STABLE_LAST) begin
          valid_d   = 1'b0;
          col_idx_d = col_idx_q + 2'd1;
          dwell_d   = '0;
          state_d   = S_SCAN;
        end else begin
          stable_d = stable_q + SW'(1);
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  assign kp.col_o          = ~(4'b0001 << col_idx_q);
  assign kp.keyboard_val_o = val_q;
  assign kp.key_valid_o    = valid_q;
  assign kp.key_pulse_o    = pulse_q;
  assign state_o           = state_q;

endmodule
